// File: rtl/fp_act_pkg.sv
// Shared definitions for the fp32 activation path: 34-bit internal float layout,
// exception codes and the IEEE binary32 word layout.
package fp_act_pkg;

  localparam int unsigned FP34_W   = 34;
  localparam int unsigned IEEE32_W = 32;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MANT_W   = 23;

  // Field slices of the 34-bit internal format
  localparam int unsigned EXN_MSB  = 33;
  localparam int unsigned EXN_LSB  = 32;
  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned MANT_MSB = 22;

  localparam logic [1:0] EXN_ZERO = 2'b00;
  localparam logic [1:0] EXN_NORM = 2'b01;
  localparam logic [1:0] EXN_INF  = 2'b10;
  localparam logic [1:0] EXN_NAN  = 2'b11;

  localparam logic [EXP_W-1:0]    EXP_MAX = 8'hFF;
  localparam logic [EXP_W-1:0]    EXP_MIN = 8'h00;
  localparam logic [IEEE32_W-1:0] QNAN32  = 32'h7FC0_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } ieee32_t;

  function automatic ieee32_t pack32(input logic sign, input logic [EXP_W-1:0] exp,
                                     input logic [MANT_W-1:0] mant);
    ieee32_t w;
    w.sign = sign;
    w.exp  = exp;
    w.mant = mant;
    return w;
  endfunction

endpackage

// File: rtl/fp34_to_ieee_conv.sv
// Combinational conversion of one 34-bit internal float to IEEE binary32,
// flagging NaN, overflow and underflow events.
module fp34_to_ieee_conv
  import fp_act_pkg::*;
#(
  parameter bit CANON_NAN = 1'b1
) (
  input  logic [FP34_W-1:0]   fp_i,
  output logic [IEEE32_W-1:0] word_o,
  output logic                nan_o,
  output logic                ovf_o,
  output logic                unf_o
);

  logic [1:0]        exn;
  logic              sign;
  logic [EXP_W-1:0]  exp;
  logic [MANT_W-1:0] mant;
  ieee32_t           word;

  assign exn  = fp_i[EXN_MSB:EXN_LSB];
  assign sign = fp_i[SIGN_BIT];
  assign exp  = fp_i[EXP_MSB:EXP_LSB];
  assign mant = fp_i[MANT_MSB:0];

  always_comb begin
    word  = pack32(sign, EXP_MIN, '0);
    nan_o = 1'b0;
    ovf_o = 1'b0;
    unf_o = 1'b0;
    case (exn)
      EXN_ZERO: word = pack32(sign, EXP_MIN, '0);
      EXN_NORM: begin
        if (exp == EXP_MIN) begin
          // Subnormal range is not representable downstream: flush to signed zero
          word  = pack32(sign, EXP_MIN, '0);
          unf_o = 1'b1;
        end else if (exp == EXP_MAX) begin
          word  = pack32(sign, EXP_MAX, '0);
          ovf_o = 1'b1;
        end else begin
          word = pack32(sign, exp, mant);
        end
      end
      EXN_INF: word = pack32(sign, EXP_MAX, '0);
      default: begin
        nan_o = 1'b1;
        if (CANON_NAN) word = ieee32_t'(QNAN32);
        else           word = pack32(sign, EXP_MAX, {1'b1, mant[MANT_W-2:0]});
      end
    endcase
  end

  assign word_o = word;

endmodule

// File: rtl/fp34_to_ieee_stream.sv
// Two-stage valid/ready converter from 34-bit internal floats to IEEE binary32,
// with saturating NaN/overflow/underflow event counters.
module fp34_to_ieee_stream
  import fp_act_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter bit          CANON_NAN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FP34_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IEEE32_W-1:0] out_data,
  input  logic                clr_counts,
  output logic [CNT_W-1:0]    nan_count,
  output logic [CNT_W-1:0]    ovf_count,
  output logic [CNT_W-1:0]    unf_count
);

  logic                s1_valid_q, s1_valid_d;
  logic [FP34_W-1:0]   s1_data_q, s1_data_d;
  logic                out_valid_q, out_valid_d;
  logic [IEEE32_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]    nan_cnt_q, nan_cnt_d;
  logic [CNT_W-1:0]    ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0]    unf_cnt_q, unf_cnt_d;

  logic                adv1, adv2, in_fire;
  logic [IEEE32_W-1:0] conv_word;
  logic                conv_nan, conv_ovf, conv_unf;

  fp34_to_ieee_conv #(
    .CANON_NAN(CANON_NAN)
  ) u_conv (
    .fp_i  (s1_data_q),
    .word_o(conv_word),
    .nan_o (conv_nan),
    .ovf_o (conv_ovf),
    .unf_o (conv_unf)
  );

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] q, input logic inc,
                                                input logic clr);
    logic [CNT_W-1:0] n;
    n = q;
    if (clr)                      n = '0;
    else if (inc && (q != '1))    n = q + CNT_W'(1);
    return n;
  endfunction

  // Handshake: S2 frees up when empty or drained, S1 when it can move into S2
  always_comb begin
    adv2     = !out_valid_q || out_ready;
    adv1     = s1_valid_q && adv2;
    in_ready = !s1_valid_q || adv2;
    in_fire  = in_valid && in_ready;
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data;
    end else if (adv1) begin
      s1_valid_d = 1'b0;
    end

    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (adv1) out_data_d = conv_word;
    end

    nan_cnt_d = cnt_next(nan_cnt_q, adv1 && conv_nan, clr_counts);
    ovf_cnt_d = cnt_next(ovf_cnt_q, adv1 && conv_ovf, clr_counts);
    unf_cnt_d = cnt_next(unf_cnt_q, adv1 && conv_unf, clr_counts);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      nan_cnt_q   <= '0;
      ovf_cnt_q   <= '0;
      unf_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      nan_cnt_q   <= nan_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
      unf_cnt_q   <= unf_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign nan_count = nan_cnt_q;
  assign ovf_count = ovf_cnt_q;
  assign unf_count = unf_cnt_q;

endmodule

// File: tb/tb_fp34_to_ieee_stream.sv
// Bench for fp34_to_ieee_stream: two instances (canonical NaN / 16-bit counters and
// payload NaN / 2-bit counters) share stimulus; a scoreboard queue checks every output.
module tb_fp34_to_ieee_stream;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, clr_counts;
  logic [33:0] in_data;
  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [31:0] out_data_a, out_data_b;
  logic [15:0] nan_a, ovf_a, unf_a;
  logic [1:0]  nan_b, ovf_b, unf_b;

  always #5 clk = ~clk;

  fp34_to_ieee_stream dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .clr_counts(clr_counts), .nan_count(nan_a), .ovf_count(ovf_a), .unf_count(unf_a));

  fp34_to_ieee_stream #(.CNT_W(2), .CANON_NAN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .clr_counts(clr_counts), .nan_count(nan_b), .ovf_count(ovf_b), .unf_count(unf_b));

  typedef struct {
    logic [33:0] din;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        n, o, u;
  } vec_t;

  typedef struct {
    logic [31:0] ea;
    logic [31:0] eb;
    int          cyc;
  } sb_t;

  vec_t        tv[16];
  sb_t         sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          mn = 0, mo = 0, mu = 0;
  bit          chk_lat = 1'b0;
  logic [31:0] cur_ea, cur_eb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int sat3(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  task automatic chk_counts(input string nm);
    chk({nm, "_nan_a"}, 32'(nan_a), 32'(mn));
    chk({nm, "_ovf_a"}, 32'(ovf_a), 32'(mo));
    chk({nm, "_unf_a"}, 32'(unf_a), 32'(mu));
    chk({nm, "_nan_b"}, 32'(nan_b), 32'(sat3(mn)));
    chk({nm, "_ovf_b"}, 32'(ovf_b), 32'(sat3(mo)));
    chk({nm, "_unf_b"}, 32'(unf_b), 32'(sat3(mu)));
  endtask

  task automatic send(input vec_t v);
    bit ok, acc;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = v.din;
    cur_ea   = v.ea;
    cur_eb   = v.eb;
    mn += 32'(v.n);
    mo += 32'(v.o);
    mu += 32'(v.u);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      acc = in_ready_a;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    in_data  = {2'($urandom), $urandom};
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid_a) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_counts();
    clr_counts = 1'b1;
    @(posedge clk);
    #1;
    clr_counts = 1'b0;
    mn = 0; mo = 0; mu = 0;
  endtask

  // Monitor: pop/compare on output handshake, push expectation on input handshake
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (out_valid_a && out_ready) begin
          if (sb.size() == 0) begin
            chk("spurious_out", out_data_a, 32'hxxxx_xxxx);
          end else begin
            e = sb.pop_front();
            chk("data_a", out_data_a, e.ea);
            chk("data_b", out_data_b, e.eb);
            if (chk_lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
          end
        end
        if (in_valid && in_ready_a) sb.push_back('{cur_ea, cur_eb, cyc});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{34'h13f800000, 32'h3f800000, 32'h3f800000, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{34'h1be800000, 32'hbe800000, 32'hbe800000, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{34'h100000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1};
    tv[3]  = '{34'h180000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1};
    tv[4]  = '{34'h200000000, 32'h7f800000, 32'h7f800000, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{34'h280000000, 32'hff800000, 32'hff800000, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{34'h300000001, 32'h7fc00000, 32'h7fc00001, 1'b1, 1'b0, 1'b0};
    tv[7]  = '{34'h3ffc00001, 32'h7fc00000, 32'hffc00001, 1'b1, 1'b0, 1'b0};
    tv[8]  = '{34'h100400000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1};
    tv[9]  = '{34'h1ff800000, 32'hff800000, 32'hff800000, 1'b0, 1'b1, 1'b0};
    tv[10] = '{34'h07f7fffff, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0};
    tv[11] = '{34'h0ff7fffff, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0};
    tv[12] = '{34'h17f7fffff, 32'h7f7fffff, 32'h7f7fffff, 1'b0, 1'b0, 1'b0};
    tv[13] = '{34'h100800000, 32'h00800000, 32'h00800000, 1'b0, 1'b0, 1'b0};
    tv[14] = '{34'h37f800000, 32'h7fc00000, 32'h7fc00000, 1'b1, 1'b0, 1'b0};
    tv[15] = '{34'h2ff812345, 32'hff800000, 32'hff800000, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clr_counts = 1'b0;
    cur_ea = '0; cur_eb = '0;
    #2;
    chk("rst_out_valid", 32'(out_valid_a), 32'd0);
    chk("rst_out_data", out_data_a, 32'd0);
    chk_counts("rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready_a), 32'd1);

    // Passthrough back-to-back with latency check
    chk_lat = 1'b1;
    send(tv[0]);
    send(tv[1]);
    drain();
    chk_lat = 1'b0;
    chk_counts("pass");

    // Specials, range edges and misc vectors streamed at full rate
    for (int i = 2; i < 16; i++) send(tv[i]);
    drain();
    chk_counts("table");

    // Backpressure: two beats fill the pipe, NaN held in S1 during the stall
    clear_counts();
    chk_counts("clr_idle");
    out_ready = 1'b0;
    send(tv[0]);
    send(tv[6]);
    in_valid = 1'b1;
    in_data  = tv[12].din;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready_a), 32'd0);
      chk("stall_out_valid", 32'(out_valid_a), 32'd1);
      chk("stall_out_data", out_data_a, tv[0].ea);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(tv[12]);
    send(tv[8]);
    send(tv[14]);
    drain();
    chk_counts("bp");

    // Saturation on the 2-bit counters
    clear_counts();
    for (int i = 0; i < 5; i++) send(tv[6]);
    drain();
    chk_counts("sat");

    // Clear coincides with a NaN moving S1->S2
    send(tv[7]);
    clr_counts = 1'b1;
    @(posedge clk);
    #1;
    clr_counts = 1'b0;
    mn = 0; mo = 0; mu = 0;
    drain();
    chk_counts("clr_win");

    // Asynchronous reset with two beats in flight
    send(tv[6]);
    send(tv[9]);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid_a), 32'd0);
    chk("arst_out_data", out_data_a, 32'd0);
    sb.delete();
    mn = 0; mo = 0; mu = 0;
    chk_counts("arst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 32'(out_valid_a), 32'd0);
    end
    @(posedge clk);
    #1;
    send(tv[13]);
    drain();
    chk_counts("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
